// File: rtl/riscv_fetch.sv
`default_nettype none
// ============================================================================
// Module   : riscv_fetch
// Purpose  : RISC-V instruction fetch stage. Holds the PC, keeps one I-memory
//            request in flight, buffers the returned word for decode and
//            applies execute-stage redirects, squashing in-flight responses.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_fetch #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,
  input  logic        fetch_accept_i,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic [31:0] icache_inst_i,
  input  logic        icache_error_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic        fetch_fault_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_req_pc, w_req_pc_nxt;
  logic        r_drop, w_drop_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pcout, w_pcout_nxt;
  logic        r_fault, w_fault_nxt;
  logic        w_rd;
  logic [31:0] w_target;
  logic        w_unused_bpc;

  assign w_target     = {branch_pc_i[31:2], 2'b00};
  assign w_unused_bpc = ^branch_pc_i[1:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_req_pc_nxt = r_req_pc;
    w_drop_nxt   = r_drop;
    w_instr_nxt  = r_instr;
    w_pcout_nxt  = r_pcout;
    w_fault_nxt  = r_fault;
    w_rd         = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_rd = !branch_request_i;
        if (branch_request_i) begin
          w_pc_nxt = w_target;
        end else if (icache_accept_i) begin
          w_req_pc_nxt = r_pc;
          w_pc_nxt     = r_pc + 32'd4;
          w_state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (icache_valid_i) begin
          // A redirect arriving together with the response squashes it too.
          if (r_drop || branch_request_i) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_FETCH;
            if (branch_request_i) w_pc_nxt = w_target;
          end else begin
            w_instr_nxt = icache_error_i ? 32'h0 : icache_inst_i;
            w_fault_nxt = icache_error_i;
            w_pcout_nxt = r_req_pc;
            w_state_nxt = S_HOLD;
          end
        end else if (branch_request_i) begin
          w_pc_nxt   = w_target;
          w_drop_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (branch_request_i) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_FETCH;
        end else if (fetch_accept_i) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_FETCH;
      r_pc     <= BOOT_ADDR;
      r_req_pc <= 32'h0;
      r_drop   <= 1'b0;
      r_instr  <= 32'h0;
      r_pcout  <= 32'h0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_req_pc <= w_req_pc_nxt;
      r_drop   <= w_drop_nxt;
      r_instr  <= w_instr_nxt;
      r_pcout  <= w_pcout_nxt;
      r_fault  <= w_fault_nxt;
    end
  end

  assign icache_rd_o   = w_rd;
  assign icache_pc_o   = r_pc;
  assign fetch_valid_o = (r_state == S_HOLD);
  assign fetch_instr_o = r_instr;
  assign fetch_pc_o    = r_pcout;
  assign fetch_fault_o = r_fault;

endmodule
`default_nettype wire
